// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router control path: FSM state encoding,
// destination address constants and a small per-port select helper.
package router_pkg;

  // Controller states, 3-bit binary encoding.
  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    WAIT_TILL_EMPTY    = 3'd3,
    CHECK_PARITY_ERROR = 3'd4,
    LOAD_PARITY        = 3'd5,
    FIFO_FULL_STATE    = 3'd6,
    LOAD_AFTER_FULL    = 3'd7
  } router_state_t;

  // Destination addresses carried in header bits [1:0].
  localparam logic [1:0] ADDR_0       = 2'd0;
  localparam logic [1:0] ADDR_1       = 2'd1;
  localparam logic [1:0] ADDR_2       = 2'd2;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

  // Pick the per-destination flag addressed by idx; the invalid address
  // never selects anything.
  function automatic logic port_sel(input logic [1:0] idx,
                                    input logic       f0,
                                    input logic       f1,
                                    input logic       f2);
    logic r;
    case (idx)
      ADDR_0:  r = f0;
      ADDR_1:  r = f1;
      ADDR_2:  r = f2;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Router control FSM: decodes the header address, waits for the destination
// FIFO to drain, then sequences the packet register through first-data,
// payload, full-stall, after-full and parity phases. All outputs are a pure
// decode of the state register.
module router_fsm
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy
);

  router_state_t r_state;
  router_state_t w_next_state;
  logic [1:0]    r_addr_q;
  logic [1:0]    w_addr_next;
  logic          w_hdr_ok;
  logic          w_hdr_empty;
  logic          w_wait_empty;
  logic          w_soft_rst;

  // A header is accepted only while decoding, with valid data and a real port.
  assign w_hdr_ok     = (r_state == DECODE_ADDRESS) && pkt_valid &&
                        (data_in != ADDR_INVALID);
  // Emptiness of the port named by the incoming header.
  assign w_hdr_empty  = port_sel(data_in, fifo_empty_0, fifo_empty_1, fifo_empty_2);
  // Emptiness of the port already latched for this packet.
  assign w_wait_empty = port_sel(r_addr_q, fifo_empty_0, fifo_empty_1, fifo_empty_2);
  // Timeout reset only counts when it belongs to the packet's own port.
  assign w_soft_rst   = port_sel(r_addr_q, soft_reset_0, soft_reset_1, soft_reset_2);

  // Next-state and address-latch selection.
  always_comb begin
    w_next_state = r_state;
    w_addr_next  = r_addr_q;
    if (w_hdr_ok) begin
      w_addr_next = data_in;
    end else begin
      w_addr_next = r_addr_q;
    end
    if ((r_state != DECODE_ADDRESS) && w_soft_rst) begin
      w_next_state = DECODE_ADDRESS;
    end else begin
      case (r_state)
        DECODE_ADDRESS: begin
          if (w_hdr_ok) begin
            w_next_state = w_hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end else begin
            w_next_state = DECODE_ADDRESS;
          end
        end
        WAIT_TILL_EMPTY: begin
          if (w_wait_empty) w_next_state = LOAD_FIRST_DATA;
          else              w_next_state = WAIT_TILL_EMPTY;
        end
        LOAD_FIRST_DATA: w_next_state = LOAD_DATA;
        LOAD_DATA: begin
          // A full FIFO outranks the end of the payload.
          if (fifo_full)       w_next_state = FIFO_FULL_STATE;
          else if (!pkt_valid) w_next_state = LOAD_PARITY;
          else                 w_next_state = LOAD_DATA;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) w_next_state = LOAD_AFTER_FULL;
          else            w_next_state = FIFO_FULL_STATE;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        w_next_state = DECODE_ADDRESS;
          else if (low_pkt_valid) w_next_state = LOAD_PARITY;
          else                    w_next_state = LOAD_DATA;
        end
        LOAD_PARITY: w_next_state = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          if (fifo_full) w_next_state = FIFO_FULL_STATE;
          else           w_next_state = DECODE_ADDRESS;
        end
        default: w_next_state = DECODE_ADDRESS;
      endcase
    end
  end

  // State and latched destination address, cleared by the async reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= DECODE_ADDRESS;
      r_addr_q <= ADDR_0;
    end else begin
      r_state  <= w_next_state;
      r_addr_q <= w_addr_next;
    end
  end

  // Moore output decode straight from the state register.
  assign detect_add    = (r_state == DECODE_ADDRESS);
  assign lfd_state     = (r_state == LOAD_FIRST_DATA);
  assign ld_state      = (r_state == LOAD_DATA);
  assign laf_state     = (r_state == LOAD_AFTER_FULL);
  assign full_state    = (r_state == FIFO_FULL_STATE);
  assign rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
  assign write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                         (r_state == LOAD_AFTER_FULL);
  assign busy          = (r_state != DECODE_ADDRESS) && (r_state != LOAD_DATA);

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural packet-phase model.
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [1:0] data_in = 2'd0;
  logic       fifo_full = 1'b0;
  logic       fifo_empty_0 = 1'b1, fifo_empty_1 = 1'b1, fifo_empty_2 = 1'b1;
  logic       soft_reset_0 = 1'b0, soft_reset_1 = 1'b0, soft_reset_2 = 1'b0;
  logic       parity_done = 1'b0;
  logic       low_pkt_valid = 1'b0;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, write_enb_reg, busy;

  int checks = 0;
  int errors = 0;

  router_fsm dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0),
    .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid), .detect_add(detect_add),
    .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy)
  );

  always #5 clock = ~clock;

  // Packet phases of the reference model (bench-local numbering).
  localparam int P_DEC = 0, P_WAIT = 1, P_LFD = 2, P_LD = 3,
                 P_FULL = 4, P_LAF = 5, P_LP = 6, P_CPE = 7;

  int         m_ph   = P_DEC;
  logic [1:0] m_addr = 2'd0;

  // Expected output vector {detect,lfd,ld,laf,full,rst_int,wen,busy} per phase.
  function automatic logic [7:0] exp_vec(input int ph);
    logic [7:0] v;
    case (ph)
      P_DEC:   v = 8'b1000_0000;
      P_WAIT:  v = 8'b0000_0001;
      P_LFD:   v = 8'b0100_0001;
      P_LD:    v = 8'b0010_0010;
      P_FULL:  v = 8'b0000_1001;
      P_LAF:   v = 8'b0001_0011;
      P_LP:    v = 8'b0000_0011;
      P_CPE:   v = 8'b0000_0101;
      default: v = 8'hxx;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] dut_vec();
    return {detect_add, lfd_state, ld_state, laf_state, full_state,
            rst_int_reg, write_enb_reg, busy};
  endfunction

  // Advance the model by one clock using the inputs the DUT just sampled.
  task automatic model_step();
    logic [2:0] empt;
    logic [2:0] srst;
    empt = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    srst = {soft_reset_2, soft_reset_1, soft_reset_0};
    if (!reset) begin
      m_ph = P_DEC; m_addr = 2'd0;
    end else if (m_ph != P_DEC && srst[m_addr]) begin
      m_ph = P_DEC;
    end else begin
      case (m_ph)
        P_DEC: if (pkt_valid && data_in != 2'd3) begin
          m_addr = data_in;
          m_ph = empt[data_in] ? P_LFD : P_WAIT;
        end
        P_WAIT: if (empt[m_addr]) m_ph = P_LFD;
        P_LFD:  m_ph = P_LD;
        P_LD:   if (fifo_full) m_ph = P_FULL; else if (!pkt_valid) m_ph = P_LP;
        P_FULL: if (!fifo_full) m_ph = P_LAF;
        P_LAF:  m_ph = parity_done ? P_DEC : (low_pkt_valid ? P_LP : P_LD);
        P_LP:   m_ph = P_CPE;
        P_CPE:  m_ph = fifo_full ? P_FULL : P_DEC;
        default: m_ph = P_DEC;
      endcase
    end
  endtask

  task automatic check_vec(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = dut_vec();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: model follows the edge, DUT checked 1 time unit later.
  task automatic step(input string tag);
    @(posedge clock);
    model_step();
    #1;
    check_vec(tag, exp_vec(m_ph));
  endtask

  task automatic check_addr(input string tag);
    checks++;
    assert (dut.r_addr_q === m_addr) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, dut.r_addr_q, m_addr);
    end
  endtask

  task automatic check_count(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int wen_cnt;
    int rst_cnt;

    // Reset held for two cycles.
    #1;
    check_vec("reset_async", 8'b1000_0000);
    step("reset_c1");
    step("reset_c2");
    reset = 1'b1;
    step("reset_release");
    check_vec("reset_idle", exp_vec(P_DEC));
    check_addr("reset_addr");

    // Header 8'h06: addr 2, one payload byte, destination empty.
    data_in = 2'd2; pkt_valid = 1'b1; fifo_empty_2 = 1'b1;
    wen_cnt = 0; rst_cnt = 0;
    step("h06_lfd"); check_vec("h06_lfd_c", exp_vec(P_LFD));
    data_in = 2'd1;
    step("h06_ld");  check_vec("h06_ld_c", exp_vec(P_LD));
    wen_cnt += int'(write_enb_reg);
    pkt_valid = 1'b0;
    step("h06_lp");  check_vec("h06_lp_c", exp_vec(P_LP));
    wen_cnt += int'(write_enb_reg);
    step("h06_cpe"); check_vec("h06_cpe_c", exp_vec(P_CPE));
    wen_cnt += int'(write_enb_reg); rst_cnt += int'(rst_int_reg);
    step("h06_dec"); check_vec("h06_dec_c", exp_vec(P_DEC));
    wen_cnt += int'(write_enb_reg); rst_cnt += int'(rst_int_reg);
    check_count("h06_wen_cycles", wen_cnt, 2);
    check_count("h06_rst_int_cycles", rst_cnt, 1);
    check_addr("h06_addr");

    // Addr 1 with its FIFO busy for 5 cycles.
    data_in = 2'd1; pkt_valid = 1'b1; fifo_empty_1 = 1'b0;
    step("wait_enter"); check_vec("wait_c0", exp_vec(P_WAIT));
    for (int i = 1; i < 5; i++) begin
      step("wait_hold"); check_vec("wait_hold_c", exp_vec(P_WAIT));
    end
    fifo_empty_1 = 1'b1;
    step("wait_lfd"); check_vec("wait_lfd_c", exp_vec(P_LFD));
    step("wait_ld");  check_vec("wait_ld_c", exp_vec(P_LD));

    // FIFO full for three cycles in LOAD_DATA, then low_pkt_valid path.
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        @(negedge clock);
      end
      step("full_hold"); check_vec("full_hold_c", exp_vec(P_FULL));
      if (i == 2) fifo_full = 1'b0;
    end
    step("laf"); check_vec("laf_c", exp_vec(P_LAF));
    low_pkt_valid = 1'b1;
    step("laf_lp"); check_vec("laf_lp_c", exp_vec(P_LP));
    low_pkt_valid = 1'b0; pkt_valid = 1'b0;
    step("laf_cpe");
    step("laf_dec"); check_vec("laf_dec_c", exp_vec(P_DEC));

    // Addr 0 in LOAD_DATA: foreign soft reset ignored, own one aborts.
    data_in = 2'd0; pkt_valid = 1'b1; fifo_empty_0 = 1'b1;
    step("sr_lfd");
    step("sr_ld"); check_vec("sr_ld_c", exp_vec(P_LD));
    soft_reset_1 = 1'b1;
    step("sr_other"); check_vec("sr_other_c", exp_vec(P_LD));
    soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
    step("sr_own"); check_vec("sr_own_c", exp_vec(P_DEC));
    soft_reset_0 = 1'b0; pkt_valid = 1'b0;

    // Invalid header address stays in decode, address untouched.
    data_in = 2'd3; pkt_valid = 1'b1;
    step("inv_hdr"); check_vec("inv_hdr_c", exp_vec(P_DEC));
    step("inv_hdr2");
    check_addr("inv_addr");

    // Async reset mid-packet.
    data_in = 2'd2; fifo_empty_2 = 1'b1;
    step("mid_lfd");
    step("mid_ld");
    #2 reset = 1'b0;
    #1;
    m_ph = P_DEC; m_addr = 2'd0;
    check_vec("mid_reset_async", exp_vec(P_DEC));
    pkt_valid = 1'b0;
    step("mid_reset_hold");
    reset = 1'b1;
    step("mid_after"); check_addr("mid_addr");

    // Random traffic checked every cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      pkt_valid     = ($urandom_range(3) != 0);
      data_in       = 2'($urandom_range(3));
      fifo_full     = ($urandom_range(3) == 0);
      fifo_empty_0  = ($urandom_range(2) != 0);
      fifo_empty_1  = ($urandom_range(2) != 0);
      fifo_empty_2  = ($urandom_range(2) != 0);
      soft_reset_0  = ($urandom_range(15) == 0);
      soft_reset_1  = ($urandom_range(15) == 0);
      soft_reset_2  = ($urandom_range(15) == 0);
      parity_done   = ($urandom_range(3) == 0);
      low_pkt_valid = ($urandom_range(2) == 0);
      reset         = ($urandom_range(199) != 0);
      if (!reset) begin
        #1;
        m_ph = P_DEC; m_addr = 2'd0;
        check_vec("rnd_async_reset", exp_vec(P_DEC));
      end
      step("rnd");
      if ((n % 64) == 0) check_addr("rnd_addr");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
